// File: rtl/lcd_pkg.sv
// Shared opcode set and scheduler state encoding for the LCD command path.
// Opcodes above OPC_MAX are reserved and may be filtered by the scheduler.
package lcd_pkg;

  localparam logic [3:0] OPC_WRITE       = 4'd0;
  localparam logic [3:0] OPC_READ        = 4'd1;
  localparam logic [3:0] OPC_SHIFT_UP    = 4'd2;
  localparam logic [3:0] OPC_SHIFT_DOWN  = 4'd3;
  localparam logic [3:0] OPC_SHIFT_RIGHT = 4'd4;
  localparam logic [3:0] OPC_SHIFT_LEFT  = 4'd5;
  localparam logic [3:0] OPC_ZOOM_IN     = 4'd6;
  localparam logic [3:0] OPC_ZOOM_OUT    = 4'd7;
  localparam logic [3:0] OPC_BRIGHT_UP   = 4'd8;
  localparam logic [3:0] OPC_BRIGHT_DN   = 4'd9;
  localparam logic [3:0] OPC_MIRROR_X    = 4'd10;
  localparam logic [3:0] OPC_MIRROR_Y    = 4'd11;

  localparam logic [3:0] OPC_MAX = OPC_MIRROR_Y;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_WAITB,
    S_WAITD,
    S_FIN
  } sched_state_e;

  function automatic logic is_reserved(input logic [3:0] op);
    return op > OPC_MAX;
  endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous opcode FIFO with a combinational head and async active-low reset.
// Push is ignored when full, pop is ignored when empty.
module lcd_cmd_fifo
  import lcd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_cmd_sched.sv
// Buffers host opcodes and issues them to the LCD controller one at a time.
// Define LCD_CMD_FILTER_EN to silently drop reserved opcodes (12-15).
module lcd_cmd_sched
  import lcd_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       host_cmd,
  input  logic             host_valid,
  output logic             host_ready,
  output logic [3:0]       cmd,
  output logic             cmd_valid,
  input  logic             busy,
  input  logic             done,
  output logic             fin,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  sched_state_e     state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             fin_q, fin_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic             push;
  logic             pop;
  logic [3:0]       head;
  logic             full;
  logic             empty;

`ifdef LCD_CMD_FILTER_EN
  logic [CNT_W-1:0] drop_q, drop_d;
  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

  assign host_ready = !full && (state_q != S_FIN);
  assign push       = host_valid && host_ready;
  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign fin        = fin_q;
  assign issued_cnt = issued_q;

  lcd_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (4)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (host_cmd),
    .dout    (head),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    fin_d       = fin_q;
    issued_d    = issued_q;
    pop         = 1'b0;
`ifdef LCD_CMD_FILTER_EN
    drop_d      = drop_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
`ifdef LCD_CMD_FILTER_EN
          if (is_reserved(head)) begin
            pop    = 1'b1;
            drop_d = sat_inc(drop_q);
          end else
`endif
          if (!busy) begin
            pop         = 1'b1;
            cmd_d       = head;
            cmd_valid_d = 1'b1;
            issued_d    = sat_inc(issued_q);
            state_d     = S_HOLD;
          end
        end
      end
      // cmd_q still carries the opcode just issued.
      S_HOLD: begin
        state_d = (cmd_q == OPC_WRITE) ? S_WAITD : S_WAITB;
      end
      S_WAITB: begin
        if (!busy) state_d = S_IDLE;
      end
      S_WAITD: begin
        if (done) begin
          fin_d   = 1'b1;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_FIN;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      fin_q       <= 1'b0;
      issued_q    <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      fin_q       <= fin_d;
      issued_q    <= issued_d;
    end
  end

`ifdef LCD_CMD_FILTER_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_q <= '0;
    else          drop_q <= drop_d;
  end
`endif

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Randomized and directed bench for lcd_cmd_sched against a queue-based model.
// Narrow counters are used so saturation is reached within the run.
module tb_lcd_cmd_sched;

  localparam int DEPTH = 8;
  localparam int CNT_W = 3;
  localparam int SAT   = (1 << CNT_W) - 1;
`ifdef LCD_CMD_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0]       host_cmd = '0;
  logic             host_valid = 1'b0;
  logic             host_ready;
  logic [3:0]       cmd;
  logic             cmd_valid;
  logic             busy = 1'b0;
  logic             done = 1'b0;
  logic             fin;
  logic [CNT_W-1:0] issued_cnt;
  logic [CNT_W-1:0] drop_cnt;

  lcd_cmd_sched #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .host_cmd   (host_cmd),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .busy       (busy),
    .done       (done),
    .fin        (fin),
    .issued_cnt (issued_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: pending opcodes, and whether the scheduler may issue again.
  int q[$];
  bit m_free;
  bit m_want_done;
  bit m_fin;
  int m_age;
  int m_cmd, m_valid, m_iss, m_drop;

  function automatic void m_reset();
    q.delete();
    m_free = 1; m_want_done = 0; m_fin = 0; m_age = 0;
    m_cmd = 0; m_valid = 0; m_iss = 0; m_drop = 0;
  endfunction

  function automatic bit m_ready();
    return (q.size() < DEPTH) && !m_fin;
  endfunction

  function automatic void m_edge();
    bit rdy;
    rdy = m_ready();
    m_valid = 0;
    if (m_fin) begin
    end else if (m_free) begin
      if (q.size() > 0) begin
        if (FILT && q[0] >= 12) begin
          void'(q.pop_front());
          if (m_drop < SAT) m_drop++;
        end else if (!busy) begin
          m_cmd = q.pop_front();
          m_valid = 1;
          if (m_iss < SAT) m_iss++;
          m_free = 0;
          m_age = 0;
          m_want_done = (m_cmd == 0);
        end
      end
    end else begin
      // First cycle after an issue ignores busy and done entirely.
      if (m_age >= 1) begin
        if (m_want_done) begin
          if (done) m_fin = 1;
        end else if (!busy) begin
          m_free = 1;
        end
      end
      m_age++;
    end
    if (host_valid && rdy) q.push_back(int'(host_cmd));
  endfunction

  task automatic cmp_all(input string pfx);
    chk({pfx, "cmd_valid"}, cmd_valid, m_valid);
    chk({pfx, "cmd"}, cmd, m_cmd);
    chk({pfx, "host_ready"}, host_ready, m_ready());
    chk({pfx, "fin"}, fin, m_fin);
    chk({pfx, "issued_cnt"}, issued_cnt, m_iss);
    chk({pfx, "drop_cnt"}, drop_cnt, m_drop);
  endtask

  task automatic step();
    m_edge();
    @(posedge clk);
    #1;
    cmp_all("");
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push(input int c);
    host_valid = 1'b1;
    host_cmd   = 4'(c);
    step();
    host_valid = 1'b0;
  endtask

  task automatic do_reset();
    host_valid = 1'b0;
    done = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    m_reset();
    cmp_all("rst_");
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
  endtask

  initial begin
    m_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Reset while waiting on busy, with opcodes still queued.
    busy = 1'b0;
    push(3); push(5); push(7);
    busy = 1'b1;
    steps(2);
    do_reset();
    busy = 1'b0;
    steps(2);

    // Single issue latency.
    push(4);
    steps(5);

    // Busy gating between two issues.
    push(5); push(6);
    busy = 1'b1;
    steps(10);
    busy = 1'b0;
    steps(6);

    // Overfill while stalled, then drain in order.
    busy = 1'b1;
    for (int i = 1; i <= DEPTH + 2; i++) push(i);
    busy = 1'b0;
    steps(40);

    // Write then finish; the opcode behind it stays queued.
    push(0); push(3);
    steps(20);
    done = 1'b1;
    step();
    done = 1'b0;
    steps(5);
    chk("fin_sticky", fin, 1);
    chk("ready_in_fin", host_ready, 0);

    // Reserved opcodes around a normal one.
    do_reset();
    push(13); push(2); push(15);
    steps(12);

    // Randomized traffic, reset between rounds.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        host_valid = ($urandom_range(0, 1) == 1);
        host_cmd   = ($urandom_range(0, 29) == 0) ? 4'd0
                   : 4'($urandom_range(1, 15));
        busy       = ($urandom_range(0, 9) < 3);
        done       = ($urandom_range(0, 9) == 0);
        step();
      end
      host_valid = 1'b0;
      busy = 1'b0;
      done = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
